// File: rtl/dlx_fetch_pkg.sv
// dlx_fetch_pkg: shared types and constants for the DLX instruction-fetch stage.
//   - fetch_state_e : FETCH / HOLD / DRAIN fetch controller states
//   - DLX_NOP, PC_INC : bubble instruction word and sequential PC step
//   - instruction field ranges and extract helpers
// DLX documentation numbers bits MSB-first (bit 0 = MSB). This code uses ordinary
// [31:0] vectors, so DLX bit n is vector bit 31-n. For example, opcode DLX[0:5]
// maps to [31:26], and function DLX[26:31] maps to [5:0].
package dlx_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    HOLD  = 2'd1,  // fetched word parked in skid buffer while stalled
    DRAIN = 2'd2   // discarding the reply to a request orphaned by a redirect
  } fetch_state_e;

  localparam logic [31:0] DLX_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC  = 32'd4;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;

  function automatic logic [5:0] dlx_opcode(input logic [31:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

  function automatic logic [5:0] dlx_func(input logic [31:0] instr);
    return instr[FUNC_HI:FUNC_LO];
  endfunction

endpackage

// File: rtl/dlx_fetch_skid.sv
// dlx_fetch_skid: one-entry buffer that parks a fetched instruction and its
// PC+4 while the decode stage is stalled.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   load_i             capture instr_i/pc4_i and mark the entry valid
//   clear_i            empty the buffer (takes priority over load_i)
//   instr_i, pc4_i     data to capture
//   valid_o            buffer holds an entry
//   instr_o, pc4_o     buffered data
module dlx_fetch_skid
  import dlx_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  // NOTE: the data registers are reset as well as the valid flag. The buffer is
  // a single entry, and resetting it keeps X out of the outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= DLX_NOP;
      pc4_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/dlx_fetch_stage.sv
// dlx_fetch_stage: DLX instruction fetch plus the IF/ID pipeline register.
// This block drives the PC and the req/ack instruction-memory handshake. It
// absorbs hazard stalls through a one-entry skid buffer and flushes on
// branch/jump redirects coming from ID.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/imem_addr         fetch request; the address holds until ack
//   imem_ack/imem_rdata        reply strobe and instruction word
//   stall                      hold the IF/ID contents
//   redirect/redirect_pc       taken branch/jump; low two bits of pc are ignored
//   ifid_valid/instr/pc4       IF/ID register contents
//   ifid_opcode/ifid_func      field slices of ifid_instr
// Optional (`define DLX_FETCH_PERF_EN): fetch_count, bubble_count counters.
module dlx_fetch_stage
  import dlx_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func
`ifdef DLX_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         req_q, req_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic         ifid_we;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc4;
  logic         ack;
  logic [31:0]  pc_plus4;

  // An ack that arrives while no request is outstanding is ignored.
  assign ack      = req_q & imem_ack;
  assign pc_plus4 = pc_q + PC_INC;

  // NOTE: every signal gets a default first, so no path through the case leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ifid_we      = 1'b0;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_we      = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = DLX_NOP;
      skid_clear   = 1'b1;
      if (req_q && !imem_ack) begin
        // The reply to the old request is still coming. Keep that address on
        // the bus until the reply arrives, then drop it.
        state_d = DRAIN;
        if (state_q == FETCH) drain_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (stall) begin
            if (ack) begin
              skid_load = 1'b1;
              pc_d      = pc_plus4;
              state_d   = HOLD;
            end
          end else begin
            ifid_we = 1'b1;
            if (ack) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = pc_plus4;
              pc_d         = pc_plus4;
            end else begin
              ifid_valid_d = 1'b0;
              ifid_instr_d = DLX_NOP;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_we      = 1'b1;
            ifid_valid_d = skid_valid;
            ifid_instr_d = skid_instr;
            ifid_pc4_d   = skid_pc4;
            skid_clear   = 1'b1;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (!stall) begin
            ifid_we      = 1'b1;
            ifid_valid_d = 1'b0;
            ifid_instr_d = DLX_NOP;
          end
          if (ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end

    // Registered request. It stays low in HOLD, and it also stays low in the
    // first cycle after reset because the reset value is 0.
    req_d = (state_d != HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every flop
  // samples the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= DLX_NOP;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      req_q        <= req_d;
      if (ifid_we) begin
        ifid_valid_q <= ifid_valid_d;
        ifid_instr_q <= ifid_instr_d;
        ifid_pc4_q   <= ifid_pc4_d;
      end
    end
  end

  dlx_fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc4_i   (pc_plus4),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  assign imem_req    = req_q;
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_opcode = dlx_opcode(ifid_instr_q);
  assign ifid_func   = dlx_func(ifid_instr_q);

`ifdef DLX_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Every IF/ID write is either a real instruction or a NOP bubble. Flushes
  // count as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (ifid_we) begin
      if (ifid_valid_d) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      else              bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// Testbench for dlx_fetch_stage. A latency-programmable memory responder feeds
// the DUT. Each accepted reply is pushed to a scoreboard queue and popped when a
// fresh IF/ID entry appears. Field decode runs from a vector table; stall,
// redirect, wrap and reset corner cases are hand-written sequences.
module tb_dlx_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;
`ifdef DLX_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  dlx_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_opcode (ifid_opcode),
    .ifid_func   (ifid_func)
`ifdef DLX_FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_t;

  typedef struct {
    int          lat;
    logic [31:0] word;
    logic [5:0]  opc;
    logic [5:0]  fn;
  } vec_t;

  sb_t         exp_q[$];
  vec_t        vecs[5];
  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  bit          stale = 0;
  bit          spur = 0;
  bit          use_ovr = 0;
  logic [31:0] ovr_word = '0;
  bit          last_stall = 0;
  bit          last_redirect = 0;
  int          m_fetch = 0;
  int          m_bubble = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic reset_model();
    wait_cnt = 0;
    stale    = 0;
    m_fetch  = 0;
    m_bubble = 0;
    exp_q.delete();
  endtask

  // Called at a negedge. It drives the memory reply for the coming edge, steps
  // one cycle, and then scores the IF/ID contents at the next negedge.
  task automatic tick(output bit fresh);
    logic        req_s;
    logic [31:0] addr_s;
    sb_t         e;
    req_s  = imem_req;
    addr_s = imem_addr;
    imem_ack   = (req_s && wait_cnt >= lat) || spur;
    imem_rdata = imem_ack ? (use_ovr ? ovr_word : addr_s) : 32'hDEAD_BEEF;
    if (redirect) exp_q.delete();
    if (req_s && imem_ack && !redirect && !stale)
      exp_q.push_back('{instr: imem_rdata, pc4: addr_s + 32'd4});
    if (req_s) begin
      if (imem_ack) begin
        wait_cnt = 0;
        stale    = 0;
      end else begin
        wait_cnt++;
        if (redirect) stale = 1;
      end
    end
    last_stall    = stall;
    last_redirect = redirect;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    spur     = 0;
    fresh    = ifid_valid && !last_stall;
    if (last_redirect) begin
      check("flush_valid", {31'd0, ifid_valid}, 32'd0);
      check("flush_instr", ifid_instr, 32'd0);
    end
    if (fresh) begin
      m_fetch++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got instr %h expected no new entry", ifid_instr);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", ifid_instr, e.instr);
        check("sb_pc4", ifid_pc4, e.pc4);
      end
    end else if (last_redirect || !last_stall) begin
      m_bubble++;
    end
  endtask

  task automatic wait_fresh(input string name, input int bound);
    bit f;
    int n;
    n = 0;
    f = 0;
    while (!f && n < bound) begin
      tick(f);
      n++;
      if (!f && !last_stall) check({name, "_bubble_instr"}, ifid_instr, 32'd0);
    end
    if (!f) timeout(name);
  endtask

  task automatic check_perf(input string name);
`ifdef DLX_FETCH_PERF_EN
    check({name, "_fetch_count"}, fetch_count, m_fetch);
    check({name, "_bubble_count"}, bubble_count, m_bubble);
`else
    checks = checks + 0;
`endif
  endtask

  initial begin
    bit          f;
    int          n;
    logic [31:0] s_addr, s_instr, s_pc4;
    logic        s_valid;

    vecs[0] = '{lat: 0, word: 32'h2001_0005, opc: 6'h08, fn: 6'h05};
    vecs[1] = '{lat: 1, word: 32'hFC00_003F, opc: 6'h3F, fn: 6'h3F};
    vecs[2] = '{lat: 2, word: 32'h0400_0020, opc: 6'h01, fn: 6'h20};
    vecs[3] = '{lat: 0, word: 32'h8C00_0000, opc: 6'h23, fn: 6'h00};
    vecs[4] = '{lat: 3, word: 32'h0000_0000, opc: 6'h00, fn: 6'h00};

    // Reset state
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc4", ifid_pc4, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check_perf("rst");

    // First cycle after release: no request yet, so a spurious ack is ignored
    rst_n = 1'b1;
    spur = 1; use_ovr = 1; ovr_word = 32'hBAD0_0BAD;
    tick(f);
    use_ovr = 0;
    check("post_rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Zero-wait stream: one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      check("stream_addr", imem_addr, RST_PC + 32'(4 * i));
      tick(f);
      check("stream_fresh", {31'd0, f}, 32'd1);
      check("stream_instr", ifid_instr, RST_PC + 32'(4 * i));
      check("stream_pc4", ifid_pc4, RST_PC + 32'(4 * i + 4));
    end

    // Decode field table
    use_ovr = 1;
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      ovr_word = vecs[i].word;
      wait_fresh("vec", 10);
      check("vec_instr", ifid_instr, vecs[i].word);
      check("vec_opcode", {26'd0, ifid_opcode}, {26'd0, vecs[i].opc});
      check("vec_func", {26'd0, ifid_func}, {26'd0, vecs[i].fn});
    end

    // Two-cycle memory at address 0
    lat = 2; ovr_word = 32'h0400_0020;
    redirect = 1'b1; redirect_pc = 32'h0; tick(f); redirect = 1'b0;
    n = 0;
    while (imem_addr != 32'h0 && n < 8) begin tick(f); n++; end
    if (imem_addr != 32'h0) timeout("lat2_drain");
    for (int i = 0; i < 3; i++) begin
      check("lat2_addr", imem_addr, 32'h0);
      check("lat2_req", {31'd0, imem_req}, 32'd1);
      tick(f);
      if (i < 2) begin
        check("lat2_wait_valid", {31'd0, ifid_valid}, 32'd0);
        check("lat2_wait_instr", ifid_instr, 32'd0);
      end
    end
    check("lat2_fresh", {31'd0, f}, 32'd1);
    check("lat2_opcode", {26'd0, ifid_opcode}, 32'h01);
    check("lat2_func", {26'd0, ifid_func}, 32'h20);
    check("lat2_pc4", ifid_pc4, 32'h4);

    // Stall for 3 cycles with an ack in the first of them
    lat = 0; ovr_word = 32'h2001_0005;
    s_addr = imem_addr; s_instr = ifid_instr; s_pc4 = ifid_pc4; s_valid = ifid_valid;
    stall = 1'b1;
    tick(f);
    for (int i = 0; i < 3; i++) begin
      check("hold_instr", ifid_instr, s_instr);
      check("hold_pc4", ifid_pc4, s_pc4);
      check("hold_valid", {31'd0, ifid_valid}, {31'd0, s_valid});
      check("hold_req", {31'd0, imem_req}, 32'd0);
      if (i == 1) begin spur = 1; ovr_word = 32'hBAD0_0BAD; end
      if (i < 2) tick(f);
    end
    stall = 1'b0; use_ovr = 0;
    tick(f);
    check("unstall_fresh", {31'd0, f}, 32'd1);
    check("unstall_instr", ifid_instr, 32'h2001_0005);
    check("unstall_pc4", ifid_pc4, s_addr + 32'd4);
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    check("unstall_addr", imem_addr, s_addr + 32'd4);
    tick(f);
    check("after_stall_instr", ifid_instr, s_addr + 32'd4);

    // Redirect (twice) while a 3-cycle request to 0x20 is pending
    redirect = 1'b1; redirect_pc = 32'h20; tick(f); redirect = 1'b0;
    check("to20_addr", imem_addr, 32'h20);
    lat = 3;
    tick(f);
    redirect = 1'b1; redirect_pc = 32'h300; tick(f);
    redirect_pc = 32'h400; tick(f);
    redirect = 1'b0;
    check("drain_addr", imem_addr, 32'h20);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    tick(f);
    check("drain_done_addr", imem_addr, 32'h400);
    check("drain_done_valid", {31'd0, ifid_valid}, 32'd0);
    wait_fresh("redir", 10);
    check("redir_instr", ifid_instr, 32'h400);
    check("redir_pc4", ifid_pc4, 32'h404);

    // Redirect + stall + ack together, low redirect_pc bits ignored
    lat = 0;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h603;
    tick(f);
    check("rs_req", {31'd0, imem_req}, 32'd1);
    check("rs_addr", imem_addr, 32'h600);
    stall = 1'b0; redirect = 1'b0;
    tick(f);
    check("rs_fresh", {31'd0, f}, 32'd1);
    check("rs_instr", ifid_instr, 32'h600);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(f); redirect = 1'b0;
    tick(f);
    check("wrap_instr", ifid_instr, 32'hFFFF_FFFC);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of DRAIN
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h800; tick(f); redirect = 1'b0;
    tick(f);
    check("pre_rst_drain_addr", imem_addr, 32'h0);
    check_perf("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("mid_rst_instr", ifid_instr, 32'd0);
    check("mid_rst_pc4", ifid_pc4, 32'd0);
    check("mid_rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    lat = 0;
    check_perf("mid_rst");
    tick(f);
    check("restart_addr", imem_addr, RST_PC);
    tick(f);
    check("restart_instr", ifid_instr, RST_PC);
    check("restart_pc4", ifid_pc4, RST_PC + 32'd4);
    check_perf("end");
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dlx_fetch_stage.md
Name: dlx_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined DLX, directly upstream of the control decoder.
- Runs the PC and a req/ack handshake to instruction memory, and absorbs stalls from the hazard unit.
- Flushes on taken branch/jump redirects from ID.
- Presents the registered instruction, the PC+4 link value and the decoded OpCode/Function fields to the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [30:31] must be 00.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req high and no ack.
- imem_ack  in  1  data-valid strobe; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; valid only when imem_ack is high.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect  in  1  taken branch/jump resolved in ID.
- redirect_pc  in  32  new PC; bits [30:31] forced to 0.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  registered instruction, bit 0 = MSB.
- ifid_pc4  out  32  address of ifid_instr + 4; JAL link value.
- ifid_opcode  out  6  ifid_instr[0:5]; wired, not registered separately.
- ifid_func  out  6  ifid_instr[26:31]; wired.

Behaviour:
- Reset (async, any state) sets:
  - pc=RESET_PC; state=FETCH; imem_req=0.
  - ifid_valid=0; ifid_instr=NOP (32'h0000_0000); ifid_pc4=0; skid buffer empty.
- Handshake: imem_req=1 with imem_addr=pc in FETCH from the first cycle after rst_n rises.
  - Request completes on the cycle imem_ack=1.
  - Address must not change before ack.
  - imem_ack while imem_req=0 is ignored.
- FETCH, ack, no stall, no redirect:
  - ifid_instr<=imem_rdata; ifid_pc4<=pc+4; ifid_valid<=1; pc<=pc+4.
  - Throughput is 1 instruction/cycle with a zero-wait memory.
- FETCH, no ack, no stall: ifid_valid<=0 and ifid_instr<=NOP (bubble).
- stall=1: IF/ID holds all values.
  - If ack arrives in FETCH, imem_rdata and pc+4 go to the skid buffer, pc<=pc+4, and the block enters HOLD.
  - In HOLD, imem_req=0.
- HOLD, stall falls: skid moves to IF/ID with ifid_valid<=1; return to FETCH, which requests the next pc in the following cycle.
- Redirect has priority over stall and ack, but not over reset.
  - pc<=redirect_pc; ifid_valid<=0; ifid_instr<=NOP; skid cleared.
  - If a request is outstanding (imem_req=1, no ack this cycle), enter DRAIN. Otherwise go to FETCH.
- DRAIN: imem_req stays high with the old address; returned data is discarded on ack; then FETCH at the new pc.
  - A redirect during DRAIN updates pc and stays in DRAIN.
- Ack coincident with redirect: the data is discarded.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- DLX_FETCH_PERF_EN defined adds two output ports, both reset to 0:
  - fetch_count (32): increments on each instruction written into IF/ID.
  - bubble_count (32): increments on each cycle IF/ID is loaded with NOP for lack of ack, including flush cycles.
  - Both wrap at 2^32.
- DLX_FETCH_PERF_EN undefined: the ports and counters are absent, with no other change.

Decomposition:
- Package dlx_fetch_pkg: state enum {FETCH, HOLD, DRAIN}, DLX_NOP constant, PC_INC=4, instruction field bit ranges (opcode [0:5], function [26:31]).
- Sub-module dlx_fetch_skid: a one-entry buffer holding instr and pc4 with load/clear/valid. The FSM and PC stay in the top module.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory returning addr as data → imem_addr sequence 100,104,108; ifid_instr 100,104 on consecutive cycles; ifid_pc4=104,108; ifid_valid=1.
- Memory acking 2 cycles after req → imem_addr holds 0 for 3 cycles; ifid_valid=0 and ifid_instr=0 during wait; ifid_opcode/ifid_func match the returned word's fields.
- Stall for 3 cycles while ack returns word 32'h2001_0005 → IF/ID unchanged, imem_req=0 in HOLD; after stall drops, ifid_instr=32'h2001_0005 with correct pc4, and no instruction is lost or duplicated.
- redirect to 32'h400 while a 3-cycle request to 0x20 is pending → old word discarded; next IF/ID valid entry is from 0x400; ifid_valid=0 in between.
- redirect and stall both high, with ack in the same cycle → IF/ID flushed to NOP, pc=redirect_pc, skid empty.
- rst_n asserted mid-DRAIN → outputs go to reset values immediately; fetch restarts at RESET_PC. With DLX_FETCH_PERF_EN, also check fetch_count/bubble_count against the expected counts.
